// File: rtl/vga_pkg.sv
// Shared definitions for the VGA seven-segment overlay: segment bit order,
// the active-high hex font and a half-open range helper.
package vga_pkg;

  localparam int COLOR_W_DEF = 4;

  // Segment vector is {a,b,c,d,e,f,g}; index with the SEG_* constants.
  typedef logic [6:0] seg7_t;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam seg7_t HEX_FONT [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  // True when v lies in [lo, hi); v is a non-negative local coordinate.
  function automatic logic in_rng(input logic [10:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

endpackage

// File: rtl/hex2seg7.sv
// Combinational nibble to active-high seven-segment pattern lookup.
module hex2seg7
  import vga_pkg::*;
(
  input  logic [3:0] nib_i,
  output seg7_t      seg_o
);

  assign seg_o = HEX_FONT[nib_i];

endmodule

// File: rtl/vga_seg_overlay.sv
// Multi-digit hex seven-segment overlay for the VGA pixel path, with
// frame-synchronous value latching, leading-zero blanking, blink and 2-stage pipe.
module vga_seg_overlay
  import vga_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SEG_LEN      = 50,
  parameter int SEG_THICK    = 10,
  parameter int DIGIT_GAP    = 20,
  parameter int X0           = 400,
  parameter int Y0           = 100,
  parameter int BLINK_FRAMES = 30,
  parameter int COLOR_W      = COLOR_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [9:0]              x,
  input  logic [9:0]              y,
  input  logic                    display,
  input  logic                    frame_start,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    value_valid,
  input  logic                    blank_leading,
  input  logic                    blink_en,
  input  logic [3*COLOR_W-1:0]    fg_color,
  input  logic [COLOR_W-1:0]      in_r,
  input  logic [COLOR_W-1:0]      in_g,
  input  logic [COLOR_W-1:0]      in_b,
  output logic [COLOR_W-1:0]      out_r,
  output logic [COLOR_W-1:0]      out_g,
  output logic [COLOR_W-1:0]      out_b,
  output logic                    out_display
);

  localparam int T      = SEG_THICK;
  localparam int L      = SEG_LEN;
  localparam int DIG_W  = 2*T + L;
  localparam int PITCH  = DIG_W + DIGIT_GAP;
  localparam int DIG_H  = 3*T + 2*L;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VAL_W  = 4*NUM_DIGITS;
  localparam int BCNT_W = $clog2(BLINK_FRAMES + 1);

  // value_valid is a one-cycle strobe with no back-pressure: every asserted
  // cycle is accepted, the last one before frame_start wins.
  logic [VAL_W-1:0] pend_q, shadow_q;
  logic             pend_flag_q, shadow_vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q       <= '0;
      shadow_q     <= '0;
      pend_flag_q  <= 1'b0;
      shadow_vld_q <= 1'b0;
    end else begin
      if (value_valid) pend_q <= value;
      if (frame_start && value_valid) begin
        shadow_q     <= value;
        shadow_vld_q <= 1'b1;
        pend_flag_q  <= 1'b0;
      end else if (frame_start && pend_flag_q) begin
        shadow_q     <= pend_q;
        shadow_vld_q <= 1'b1;
        pend_flag_q  <= 1'b0;
      end else if (value_valid) begin
        pend_flag_q  <= 1'b1;
      end
    end
  end

  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              bvis_q, bvis_d;

  always_comb begin
    bcnt_d = bcnt_q;
    bvis_d = bvis_q;
    if (!blink_en) begin
      bcnt_d = '0;
      bvis_d = 1'b1;
    end else if (frame_start) begin
      if (bcnt_q == BCNT_W'(BLINK_FRAMES - 1)) begin
        bcnt_d = '0;
        bvis_d = ~bvis_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_q <= '0;
      bvis_q <= 1'b1;
    end else begin
      bcnt_q <= bcnt_d;
      bvis_q <= bvis_d;
    end
  end

  // Stage 1: per-digit box compare, negative local coordinate means miss.
  logic signed [10:0]    ly_s;
  logic                  ly_in;
  logic [NUM_DIGITS-1:0] box_hit;
  logic [10:0]           lx_arr [NUM_DIGITS];

  assign ly_s  = $signed({1'b0, y}) - $signed(11'(Y0));
  assign ly_in = !ly_s[10] && (ly_s < $signed(11'(DIG_H)));

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
    logic signed [10:0] lx_s;
    assign lx_s       = $signed({1'b0, x}) - $signed(11'(X0 + k*PITCH));
    assign box_hit[k] = ly_in && !lx_s[10] && (lx_s < $signed(11'(DIG_W)));
    assign lx_arr[k]  = lx_s;
  end

  logic [IDX_W-1:0] idx_d;
  logic [10:0]      lx_d;
  logic             box_d;

  always_comb begin
    idx_d = '0;
    lx_d  = '0;
    box_d = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (box_hit[k]) begin
        idx_d = IDX_W'(k);
        lx_d  = lx_arr[k];
        box_d = 1'b1;
      end
    end
  end

  logic [IDX_W-1:0]   s1_idx_q;
  logic               s1_box_q, s1_disp_q;
  logic [10:0]        s1_lx_q, s1_ly_q;
  logic [COLOR_W-1:0] s1_r_q, s1_g_q, s1_b_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_idx_q  <= '0;
      s1_box_q  <= 1'b0;
      s1_disp_q <= 1'b0;
      s1_lx_q   <= '0;
      s1_ly_q   <= '0;
      s1_r_q    <= '0;
      s1_g_q    <= '0;
      s1_b_q    <= '0;
    end else begin
      s1_idx_q  <= idx_d;
      s1_box_q  <= box_d;
      s1_disp_q <= display;
      s1_lx_q   <= lx_d;
      s1_ly_q   <= ly_s;
      s1_r_q    <= in_r;
      s1_g_q    <= in_g;
      s1_b_q    <= in_b;
    end
  end

  // Stage 2: leading-zero chain runs from digit 0 (most significant) rightwards.
  logic [NUM_DIGITS-1:0] lead_zero;
  logic [3:0]            nib;
  logic                  blanked;

  always_comb begin
    lead_zero = '0;
    nib       = '0;
    blanked   = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      lead_zero[k] = (shadow_q[4*(NUM_DIGITS-1-k) +: 4] == 4'h0) &&
                     ((k == 0) ? 1'b1 : lead_zero[(k == 0) ? 0 : k-1]);
      if (s1_idx_q == IDX_W'(k)) begin
        nib     = shadow_q[4*(NUM_DIGITS-1-k) +: 4];
        blanked = blank_leading && lead_zero[k] && (k != NUM_DIGITS-1);
      end
    end
  end

  seg7_t glyph, seg_hit;

  hex2seg7 u_hex2seg7 (
    .nib_i (nib),
    .seg_o (glyph)
  );

  always_comb begin
    seg_hit        = '0;
    seg_hit[SEG_A] = in_rng(s1_lx_q, T, T+L)   && in_rng(s1_ly_q, 0, T);
    seg_hit[SEG_B] = in_rng(s1_lx_q, T+L, DIG_W) && in_rng(s1_ly_q, T, T+L);
    seg_hit[SEG_C] = in_rng(s1_lx_q, T+L, DIG_W) && in_rng(s1_ly_q, 2*T+L, 2*T+2*L);
    seg_hit[SEG_D] = in_rng(s1_lx_q, T, T+L)   && in_rng(s1_ly_q, 2*T+2*L, DIG_H);
    seg_hit[SEG_E] = in_rng(s1_lx_q, 0, T)     && in_rng(s1_ly_q, 2*T+L, 2*T+2*L);
    seg_hit[SEG_F] = in_rng(s1_lx_q, 0, T)     && in_rng(s1_ly_q, T, T+L);
    seg_hit[SEG_G] = in_rng(s1_lx_q, T, T+L)   && in_rng(s1_ly_q, T+L, 2*T+L);
  end

  logic lit;
  assign lit = s1_box_q && shadow_vld_q && |(seg_hit & glyph) && !blanked && bvis_q;

  logic [COLOR_W-1:0] out_r_q, out_g_q, out_b_q;
  logic               out_disp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_r_q    <= '0;
      out_g_q    <= '0;
      out_b_q    <= '0;
      out_disp_q <= 1'b0;
    end else begin
      out_disp_q <= s1_disp_q;
      if (!s1_disp_q) begin
        out_r_q <= '0;
        out_g_q <= '0;
        out_b_q <= '0;
      end else if (lit) begin
        out_r_q <= fg_color[3*COLOR_W-1:2*COLOR_W];
        out_g_q <= fg_color[2*COLOR_W-1:COLOR_W];
        out_b_q <= fg_color[COLOR_W-1:0];
      end else begin
        out_r_q <= s1_r_q;
        out_g_q <= s1_g_q;
        out_b_q <= s1_b_q;
      end
    end
  end

  assign out_r       = out_r_q;
  assign out_g       = out_g_q;
  assign out_b       = out_b_q;
  assign out_display = out_disp_q;

endmodule

// File: tb/tb_vga_seg_overlay.sv
// Directed bench for vga_seg_overlay: value latching, blanking, blink,
// geometry edges, display gating and mid-frame reset.
module tb_vga_seg_overlay;

  localparam int CW = 4;
  localparam logic [11:0] FG = 12'hC96;
  localparam logic [11:0] IN = 12'h123;

  localparam int M_ZERO = 0;
  localparam int M_IN   = 1;
  localparam int M_FG   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [9:0]    x = '0, y = '0;
  logic          display = 1'b0;
  logic          frame_start = 1'b0;
  logic [15:0]   value = '0;
  logic          value_valid = 1'b0;
  logic          blank_leading = 1'b0;
  logic          blink_en = 1'b0;
  logic [11:0]   fg_color = FG;
  logic [CW-1:0] in_r = IN[11:8], in_g = IN[7:4], in_b = IN[3:0];
  logic [CW-1:0] out_r, out_g, out_b;
  logic          out_display;

  int total = 0;
  int bad   = 0;

  vga_seg_overlay #(.BLINK_FRAMES(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .x             (x),
    .y             (y),
    .display       (display),
    .frame_start   (frame_start),
    .value         (value),
    .value_valid   (value_valid),
    .blank_leading (blank_leading),
    .blink_en      (blink_en),
    .fg_color      (fg_color),
    .in_r          (in_r),
    .in_g          (in_g),
    .in_b          (in_b),
    .out_r         (out_r),
    .out_g         (out_g),
    .out_b         (out_b),
    .out_display   (out_display)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_value(input logic [15:0] v);
    value       = v;
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic check_pix(input string tag, input int px, input int py,
                           input logic disp, input int mode);
    logic [11:0] exp;
    x       = 10'(px);
    y       = 10'(py);
    display = disp;
    tick();
    tick();
    exp = (mode == M_FG) ? FG : (mode == M_IN) ? IN : 12'h000;
    check(tag, {out_r, out_g, out_b}, exp);
    check({tag, "_disp"}, {11'd0, out_display}, {11'd0, disp});
  endtask

  initial begin
    // Scenario 1: reset and first value
    display = 1'b1;
    x = 10'd430;
    y = 10'd105;
    repeat (3) tick();
    check("rst_out", {out_r, out_g, out_b}, 12'h000);
    check("rst_disp", {11'd0, out_display}, 12'h000);
    rst = 1'b0;
    check_pix("dark_before_load", 430, 105, 1'b1, M_IN);
    load_value(16'h1234);
    frame();
    check_pix("d0_1_seg_b", 465, 135, 1'b1, M_FG);
    check_pix("d0_1_seg_f_off", 405, 135, 1'b1, M_IN);
    check_pix("d3_4_seg_g", 700, 165, 1'b1, M_FG);

    // Scenario 2: mid-frame update waits for frame_start
    load_value(16'h8888);
    check_pix("no_tear_a", 430, 105, 1'b1, M_IN);
    frame();
    check_pix("d0_8_seg_a", 430, 105, 1'b1, M_FG);
    check_pix("d0_8_seg_d", 430, 225, 1'b1, M_FG);

    // Scenario 3: leading-zero blanking
    blank_leading = 1'b1;
    load_value(16'h0005);
    frame();
    check_pix("blank_d0", 430, 105, 1'b1, M_IN);
    check_pix("blank_d1", 520, 105, 1'b1, M_IN);
    check_pix("d3_5_seg_a", 700, 105, 1'b1, M_FG);
    blank_leading = 1'b0;
    check_pix("noblank_d0", 430, 105, 1'b1, M_FG);
    blank_leading = 1'b1;
    load_value(16'h0000);
    frame();
    check_pix("zero_d3_kept", 700, 105, 1'b1, M_FG);
    check_pix("zero_d0_blank", 430, 105, 1'b1, M_IN);
    blank_leading = 1'b0;

    // Scenario 4: blink with two frames per phase
    load_value(16'h8888);
    frame();
    blink_en = 1'b1;
    tick();
    check_pix("blink_f0", 430, 105, 1'b1, M_FG);
    frame();
    check_pix("blink_f1", 430, 105, 1'b1, M_FG);
    frame();
    check_pix("blink_f2", 430, 105, 1'b1, M_IN);
    frame();
    check_pix("blink_f3", 430, 105, 1'b1, M_IN);
    frame();
    check_pix("blink_f4", 430, 105, 1'b1, M_FG);
    frame();
    frame();
    check_pix("blink_f6", 430, 105, 1'b1, M_IN);
    blink_en = 1'b0;
    frame();
    check_pix("blink_off", 430, 105, 1'b1, M_FG);

    // Scenario 5: display gating and geometry edges
    check_pix("disp_off", 430, 105, 1'b0, M_ZERO);
    check_pix("gap", 475, 105, 1'b1, M_IN);
    check_pix("left_of_d0", 395, 105, 1'b1, M_IN);
    check_pix("corner", 400, 100, 1'b1, M_IN);
    check_pix("b_right_edge", 469, 135, 1'b1, M_FG);
    check_pix("b_past_edge", 470, 135, 1'b1, M_IN);
    check_pix("digit_centre", 435, 135, 1'b1, M_IN);
    check_pix("above_top", 430, 99, 1'b1, M_IN);
    check_pix("d_bottom_row", 430, 229, 1'b1, M_FG);
    check_pix("below_bottom", 430, 230, 1'b1, M_IN);

    // Scenario 6: reset mid-frame clears shadow and pending
    check_pix("pre_rst_lit", 430, 105, 1'b1, M_FG);
    load_value(16'h8888);
    rst = 1'b1;
    tick();
    check("mid_rst_out", {out_r, out_g, out_b}, 12'h000);
    check("mid_rst_disp", {11'd0, out_display}, 12'h000);
    rst = 1'b0;
    frame();
    check_pix("post_rst_dark", 430, 105, 1'b1, M_IN);
    load_value(16'h8888);
    check_pix("post_rst_pending", 430, 105, 1'b1, M_IN);
    frame();
    check_pix("post_rst_lit", 430, 105, 1'b1, M_FG);

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
